uart_tx_arbiter: RTL and testbench

Shares the single UART transmit byte interface between NUM_REQ byte-stream requesters, for example CPU store path, debug monitor and DMA.
- Round-robin arbitration at packet granularity: a grant is held until the requester marks its last byte or MAX_BURST bytes have been sent.
- Sits between the requesters and the UART's write_enable/data_in/ready port in the SoC top level.

---
 rtl/uart_arb_pkg.sv | 8 +
 rtl/uart_tx_arbiter_rr_picker.sv | 17 +
 rtl/uart_tx_arbiter.sv | 66 ++++++
 tb/tb_uart_tx_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;
  localparam int UART_BYTE_W = 8;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: rotate-priority encoder; the first request after ptr (wrapping) wins.
module rr_picker import uart_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any_req
);
  always_comb begin
    idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
  end
  assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART byte port.
// Define UART_ARB_PRIO0_EN to make requester 0 win every arbitration it joins.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_valid,
  output logic [UART_BYTE_W-1:0]         tx_data,
  input  logic                           tx_ready,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy,
  output logic                           burst_done
);
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, rr_idx, pick_id;
  logic [BW-1:0] beat_cnt;
  logic any_req, xfer, grant_end;

  rr_picker #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req(req_valid), .ptr(rr_ptr), .idx(rr_idx), .any_req(any_req)
  );

`ifdef UART_ARB_PRIO0_EN
  assign pick_id = req_valid[0] ? '0 : rr_idx;
`else
  assign pick_id = rr_idx;
`endif

  assign busy      = state == ARB_XFER;
  assign tx_valid  = busy && req_valid[grant_id];
  assign tx_data   = req_data[grant_id*UART_BYTE_W +: UART_BYTE_W];
  assign req_ready = busy ? NUM_REQ'(tx_ready) << grant_id : '0;
  assign xfer      = tx_valid && tx_ready;
  // A packet end and the burst limit on the same byte collapse into one end event.
  assign grant_end = xfer && (req_last[grant_id] || beat_cnt == BW'(MAX_BURST - 1));

  always_comb begin
    state_nx = state;
    state_nx = busy ? (grant_end ? ARB_IDLE : ARB_XFER) : (any_req ? ARB_XFER : ARB_IDLE);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= ARB_IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      beat_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nx;
      burst_done <= grant_end;
      if (!busy && any_req) begin
        grant_id <= pick_id;
        beat_cnt <= '0;
      end else if (xfer) beat_cnt <= beat_cnt + 1'b1;
      if (grant_end) rr_ptr <= grant_id;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized packet traffic checked against a queue-level burst schedule model.
module tb_uart_tx_arbiter;
  localparam int N = 4, MB = 16, IW = 2;
  logic clk = 0, rst;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*8-1:0] req_data;
  logic tx_valid, tx_ready, busy, burst_done;
  logic [7:0] tx_data;
  logic [IW-1:0] grant_id;
  int checks = 0, errors = 0;
  logic [7:0] qd [N][$];
  bit ql [N][$];
  logic [7:0] md [N][$];
  bit ml [N][$];
  bit vld [N];
  bit mid [N];
  bit gaps, gap_chk, open;
  int ready_pct, cyc, last_xc, first_xc, m_ptr;
  int ob_id[$], ob_len[$], ex_id[$], ex_len[$];
  logic [7:0] ob_bytes[$], ex_bytes[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .burst_done(burst_done)
  );

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = vld[i];
      req_data[i*8 +: 8] = qd[i].size() > 0 ? qd[i][0] : 8'h00;
      req_last[i] = qd[i].size() > 0 ? ql[i][0] : 1'b0;
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int k = 0; k < len; k++) begin
      qd[r].push_back(8'($urandom));
      ql[r].push_back(k == len - 1);
    end
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < N; i++) if (qd[i].size() > 0) p = 1;
    return p;
  endfunction

  // Expected burst list: walk the queued packets with the round-robin rule and burst cap.
  task automatic build_expected();
    int id, n;
    bit found, lst;
    for (int i = 0; i < N; i++) begin
      md[i] = qd[i];
      ml[i] = ql[i];
    end
    while (1) begin
      found = 0;
      id = 0;
      for (int k = 1; k <= N && !found; k++) begin
        id = (m_ptr + k) % N;
        if (md[id].size() > 0) found = 1;
      end
`ifdef UART_ARB_PRIO0_EN
      if (md[0].size() > 0) begin
        id = 0;
        found = 1;
      end
`endif
      if (!found) break;
      n = 0;
      lst = 0;
      while (!lst && n < MB && md[id].size() > 0) begin
        ex_bytes.push_back(md[id].pop_front());
        lst = ml[id].pop_front();
        n++;
      end
      ex_id.push_back(id);
      ex_len.push_back(n);
      m_ptr = id;
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    bit want;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      want = busy && tx_ready && (grant_id == i);
      checks++;
      if (req_ready[i] !== want) begin
        errors++;
        $display("FAIL req_ready[%0d] cycle %0d: got %b want %b", i, cyc, req_ready[i], want);
      end
    end
    want = busy && req_valid[grant_id];
    checks++;
    if (tx_valid !== want) begin
      errors++;
      $display("FAIL tx_valid cycle %0d: got %b want %b", cyc, tx_valid, want);
    end
    if (tx_valid && qd[grant_id].size() > 0) begin
      checks++;
      if (tx_data !== qd[grant_id][0]) begin
        errors++;
        $display("FAIL tx_data cycle %0d: got %h want %h", cyc, tx_data, qd[grant_id][0]);
      end
    end
    if (burst_done) begin
      checks++;
      if (!open) begin
        errors++;
        $display("FAIL burst_done cycle %0d: got pulse want none (no open burst)", cyc);
      end
      open = 0;
    end
    if (tx_valid && tx_ready) begin
      if (first_xc < 0) first_xc = cyc;
      if (gap_chk && last_xc >= 0) begin
        checks++;
        if (cyc - last_xc != (open ? 1 : 2)) begin
          errors++;
          $display("FAIL spacing cycle %0d: got %0d want %0d", cyc, cyc - last_xc, open ? 1 : 2);
        end
      end
      if (!open) begin
        open = 1;
        ob_id.push_back(int'(grant_id));
        ob_len.push_back(0);
      end else begin
        checks++;
        if (int'(grant_id) != ob_id[ob_id.size()-1]) begin
          errors++;
          $display("FAIL grant_hold cycle %0d: got %0d want %0d", cyc, grant_id, ob_id[ob_id.size()-1]);
        end
      end
      ob_len[ob_len.size()-1] = ob_len[ob_len.size()-1] + 1;
      ob_bytes.push_back(tx_data);
      last_xc = cyc;
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(qd[i].pop_front());
        mid[i] = !ql[i].pop_front();
      end
      if (acc[i] || !vld[i])
        vld[i] = qd[i].size() > 0 && (!(gaps && mid[i]) || $urandom_range(0, 1) == 1);
    end
    tx_ready = $urandom_range(0, 99) < ready_pct;
    drive();
  endtask

  task automatic clear_obs();
    ob_id.delete(); ob_len.delete(); ob_bytes.delete();
    ex_id.delete(); ex_len.delete(); ex_bytes.delete();
    open = 0;
    last_xc = -1;
    first_xc = -1;
    cyc = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    for (int i = 0; i < N; i++) begin
      qd[i].delete(); ql[i].delete();
      vld[i] = 0;
      mid[i] = 0;
    end
    tx_ready = 0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    m_ptr = N - 1;
    gaps = 0;
    gap_chk = 0;
    ready_pct = 100;
    clear_obs();
  endtask

  task automatic run(input string name);
    int n = 0;
    build_expected();
    for (int i = 0; i < N; i++) if (!vld[i]) vld[i] = qd[i].size() > 0;
    tx_ready = $urandom_range(0, 99) < ready_pct;
    drive();
    while ((pending() || busy || open) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s timeout: got %0d cycles want under 3000", name, n);
    end
    checks++;
    if (ob_id.size() != ex_id.size()) begin
      errors++;
      $display("FAIL %s burst_count: got %0d want %0d", name, ob_id.size(), ex_id.size());
    end
    for (int b = 0; b < ex_id.size() && b < ob_id.size(); b++) begin
      checks++;
      if (ob_id[b] != ex_id[b] || ob_len[b] != ex_len[b]) begin
        errors++;
        $display("FAIL %s burst[%0d]: got id %0d len %0d want id %0d len %0d", name, b, ob_id[b], ob_len[b], ex_id[b], ex_len[b]);
      end
    end
    checks++;
    if (ob_bytes.size() != ex_bytes.size()) begin
      errors++;
      $display("FAIL %s byte_count: got %0d want %0d", name, ob_bytes.size(), ex_bytes.size());
    end else
      for (int k = 0; k < ex_bytes.size(); k++)
        if (ob_bytes[k] !== ex_bytes[k]) begin
          errors++;
          $display("FAIL %s byte[%0d]: got %h want %h", name, k, ob_bytes[k], ex_bytes[k]);
          break;
        end
  endtask

  task automatic test_reset();
    rst = 1;
    req_valid = '1;
    req_last = '0;
    req_data = '1;
    tx_ready = 1;
    @(negedge clk);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (burst_done !== 1'b0) begin errors++; $display("FAIL reset burst_done: got %b want 0", burst_done); end
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset tx_valid: got %b want 0", tx_valid); end
    if (req_ready !== '0) begin errors++; $display("FAIL reset req_ready: got %b want 0", req_ready); end
    if (grant_id !== '0) begin errors++; $display("FAIL reset grant_id: got %0d want 0", grant_id); end
  endtask

  task automatic test_single();
    do_reset();
    gap_chk = 1;
    qd[0] = '{8'h41, 8'h42, 8'h43};
    ql[0] = '{1'b0, 1'b0, 1'b1};
    run("single");
    checks++;
    if (first_xc != 1) begin
      errors++;
      $display("FAIL single first_transfer: got cycle %0d want 1", first_xc);
    end
    clear_obs();
    gap_chk = 0;
    add_pkt(0, 1);
    add_pkt(1, 1);
    run("single_ptr");
  endtask

  task automatic test_round_robin();
    do_reset();
    gap_chk = 1;
    add_pkt(0, 2); add_pkt(0, 2);
    for (int r = 1; r < N; r++) add_pkt(r, 2);
    run("round_robin");
  endtask

  task automatic test_long_stream();
    do_reset();
    gap_chk = 1;
    add_pkt(2, 40);
    for (int r = 0; r < N; r++) if (r != 2) begin add_pkt(r, 2); add_pkt(r, 2); end
    run("long_stream");
  endtask

  task automatic test_ready_toggle();
    do_reset();
    ready_pct = 50;
    for (int r = 0; r < N; r++) begin
      add_pkt(r, $urandom_range(1, 20));
      add_pkt(r, $urandom_range(1, 20));
    end
    run("ready_toggle");
  endtask

  task automatic test_valid_drop();
    do_reset();
    gaps = 1;
    ready_pct = 80;
    add_pkt(1, 6); add_pkt(1, 6);
    add_pkt(2, 3);
    run("valid_drop");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    add_pkt(1, 2);
    run("pre_reset");
    clear_obs();
    add_pkt(2, 10);
    vld[2] = 1;
    tx_ready = 1;
    drive();
    while ((ob_len.size() == 0 || ob_len[0] < 5) && n < 100) begin tick(); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL reset_mid timeout: got %0d cycles want under 100", n); end
    #2 rst = 1;
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_mid tx_valid: got %b want 0", tx_valid); end
    if (req_ready !== '0) begin errors++; $display("FAIL reset_mid req_ready: got %b want 0", req_ready); end
    if (grant_id !== '0) begin errors++; $display("FAIL reset_mid grant_id: got %0d want 0", grant_id); end
    if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_mid burst_done: got %b want 0", burst_done); end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_hold burst_done: got %b want 0", burst_done); end
    end
    do_reset();
    add_pkt(3, 2);
    add_pkt(0, 2);
    run("post_reset");
  endtask

  task automatic test_prio();
    do_reset();
    for (int k = 0; k < 3; k++) begin add_pkt(0, 2); add_pkt(3, 2); end
    run("prio");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_long_stream();
    test_ready_toggle();
    test_valid_drop();
    test_reset_mid();
    test_prio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
